lvds_rx_deserializer: RTL and testbench

Receive-side counterpart of the panel LVDS transmitter: takes the four FPD-Link-style data lanes and the clock lane, already converted to single-ended bits by IBUFDS and sampled once per bit clock. It aligns to the 7-bit clock-lane pattern, deserializes each pixel word, and decodes RGB888 plus hsync, vsync and data-enable. It also tracks the pixel position, so captured link traffic can be checked against the frame buffer contents in loopback and board bring-up.

---
 rtl/lvds_rx_deserializer.sv | 120 ++++++++++++
 tb/tb_lvds_rx_deserializer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/lvds_rx_deserializer.sv
// lvds_rx_deserializer: aligns to the LVDS clock lane, deserializes 7:1 lanes, decodes RGB888 + sync and tracks pixel position.
`timescale 1ns/1ps
module lvds_rx_deserializer #(
   parameter int unsigned LOCK_COUNT    = 4,
   parameter int unsigned UNLOCK_MISSES = 2,
   parameter logic [6:0]  CK_PATTERN    = 7'b1100011
) (
   input  logic        clk_in,
   input  logic        rst_n,
   input  logic        ck_bit,
   input  logic        rx0_bit,
   input  logic        rx1_bit,
   input  logic        rx2_bit,
   input  logic        rx3_bit,
   output logic [7:0]  red,
   output logic [7:0]  green,
   output logic [7:0]  blue,
   output logic        hsync,
   output logic        vsync,
   output logic        de,
   output logic        pixel_valid,
   output logic        frame_start,
   output logic        rsvd_err,
   output logic        locked,
   output logic [10:0] px_x,
   output logic [9:0]  px_y
);
   typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;
   state_t state, state_n;
   logic [6:0] ck_sr, l0, l1, l2, l3;
   logic [2:0] ph;
   logic [3:0] good, miss;
   logic prev_de, prev_vs, match, bnd, dec, drop;
   logic [7:0] r_w, g_w, b_w;
   assign match  = ck_sr == CK_PATTERN;
   assign bnd    = ph == 3'd6;
   assign locked = state == LOCKED;
   assign r_w = {l3[5], l3[6], l0[1], l0[2], l0[3], l0[4], l0[5], l0[6]};
   assign g_w = {l3[3], l3[4], l1[2], l1[3], l1[4], l1[5], l1[6], l0[0]};
   assign b_w = {l3[1], l3[2], l2[3], l2[4], l2[5], l2[6], l1[0], l1[1]};
   always_comb begin
      state_n = state;
      case (state)
         HUNT:    if (match) state_n = VERIFY;
         VERIFY:  if (bnd) state_n = !match ? HUNT : (good + 4'd1 == 4'(LOCK_COUNT)) ? LOCKED : VERIFY;
         LOCKED:  if (bnd && !match && miss + 4'd1 == 4'(UNLOCK_MISSES)) state_n = HUNT;
         default: state_n = HUNT;
      endcase
      dec  = state == LOCKED && bnd && match;
      drop = state == LOCKED && state_n == HUNT;
   end
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state <= HUNT;
         ph    <= 3'd0;
         good  <= 4'd0;
         miss  <= 4'd0;
         ck_sr <= 7'd0;
         l0    <= 7'd0;
         l1    <= 7'd0;
         l2    <= 7'd0;
         l3    <= 7'd0;
      end else begin
         state <= state_n;
         ck_sr <= {ck_bit, ck_sr[6:1]};
         l0    <= {rx0_bit, l0[6:1]};
         l1    <= {rx1_bit, l1[6:1]};
         l2    <= {rx2_bit, l2[6:1]};
         l3    <= {rx3_bit, l3[6:1]};
         // a HUNT match restarts the phase so the next boundary lands one full word later
         ph    <= ((state == HUNT && match) || bnd) ? 3'd0 : ph + 3'd1;
         if (state == HUNT) begin
            good <= 4'd0;
            miss <= 4'd0;
         end else if (bnd) begin
            good <= (state == VERIFY && match) ? good + 4'd1 : good;
            miss <= match ? 4'd0 : miss + 4'd1;
         end
      end
   end
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         red         <= 8'd0;
         green       <= 8'd0;
         blue        <= 8'd0;
         hsync       <= 1'b0;
         vsync       <= 1'b0;
         de          <= 1'b0;
         pixel_valid <= 1'b0;
         frame_start <= 1'b0;
         rsvd_err    <= 1'b0;
         prev_de     <= 1'b0;
         prev_vs     <= 1'b0;
         px_x        <= 11'd0;
         px_y        <= 10'd0;
      end else begin
         pixel_valid <= dec;
         frame_start <= dec && l2[1] && !prev_vs;
         rsvd_err    <= dec && !l3[0];
         if (dec) begin
            red     <= r_w;
            green   <= g_w;
            blue    <= b_w;
            hsync   <= l2[2];
            vsync   <= l2[1];
            de      <= l2[0];
            prev_de <= l2[0];
            prev_vs <= l2[1];
            px_x    <= (l2[0] && !prev_de) ? 11'd0 : (&px_x) ? px_x : px_x + 11'd1;
            // a vsync-low word clears the line count even when de falls on the same word
            px_y    <= !l2[1] ? 10'd0 : (prev_de && !l2[0] && !(&px_y)) ? px_y + 10'd1 : px_y;
         end else if (drop) begin
            prev_de <= 1'b0;
            prev_vs <= 1'b0;
            px_x    <= 11'd0;
            px_y    <= 10'd0;
         end
      end
   end
endmodule

// File: tb/tb_lvds_rx_deserializer.sv
// tb_lvds_rx_deserializer: directed stimulus with a scoreboard queue checked by an independent pixel monitor.
`timescale 1ns/1ps
module tb_lvds_rx_deserializer;
   logic clk_in = 1'b0, rst_n = 1'b0, ck_bit = 1'b0;
   logic rx0_bit = 1'b0, rx1_bit = 1'b0, rx2_bit = 1'b0, rx3_bit = 1'b0;
   logic [7:0] red, green, blue;
   logic hsync, vsync, de, pixel_valid, frame_start, rsvd_err, locked;
   logic [10:0] px_x;
   logic [9:0] px_y;
   lvds_rx_deserializer dut (
      .clk_in(clk_in), .rst_n(rst_n), .ck_bit(ck_bit),
      .rx0_bit(rx0_bit), .rx1_bit(rx1_bit), .rx2_bit(rx2_bit), .rx3_bit(rx3_bit),
      .red(red), .green(green), .blue(blue), .hsync(hsync), .vsync(vsync), .de(de),
      .pixel_valid(pixel_valid), .frame_start(frame_start), .rsvd_err(rsvd_err),
      .locked(locked), .px_x(px_x), .px_y(px_y)
   );
   always #5 clk_in = ~clk_in;
   typedef struct packed {
      logic [7:0] r, g, b;
      logic hs, vs, en, fs, re;
      logic [10:0] x;
      logic [9:0] y;
   } px_t;
   localparam logic [6:0] CKP = 7'b1100011;
   localparam logic [6:0] BAD = 7'b0000000;
   px_t q[$];
   px_t got, exp_px;
   int n_cmp = 0, n_err = 0, cyc = 0, last_pv = -100;
   int m_px, m_py;
   logic m_pde, m_pvs;
   logic s_lock[7];
   logic [10:0] s_px[7];
   logic [9:0] s_py[7];
   task automatic chk(input string n, input int a, input int e);
      n_cmp++;
      if (a !== e) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", n, a, e);
      end
   endtask
   task automatic model_clear();
      m_px = 0; m_py = 0; m_pde = 1'b0; m_pvs = 1'b0;
   endtask
   // snapshots of locked/px at each bit slot let callers see the previous word's effect
   task automatic send_word(input logic [6:0] ckw, input logic [7:0] r, g, b, input logic hs, vs, en, rsv);
      logic [6:0] w0, w1, w2, w3;
      w0 = {r[0], r[1], r[2], r[3], r[4], r[5], g[0]};
      w1 = {g[1], g[2], g[3], g[4], g[5], b[0], b[1]};
      w2 = {b[2], b[3], b[4], b[5], hs, vs, en};
      w3 = {r[6], r[7], g[6], g[7], b[6], b[7], rsv};
      for (int k = 0; k < 7; k++) begin
         @(negedge clk_in);
         s_lock[k] = locked; s_px[k] = px_x; s_py[k] = px_y;
         ck_bit = ckw[k]; rx0_bit = w0[k]; rx1_bit = w1[k]; rx2_bit = w2[k]; rx3_bit = w3[k];
      end
   endtask
   task automatic idle(input logic [6:0] ckw);
      send_word(ckw, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask
   task automatic pix(input logic [7:0] r, g, b, input logic hs, vs, en, rsv);
      px_t e;
      e.fs = vs & ~m_pvs;
      e.re = ~rsv;
      m_px = (en && !m_pde) ? 0 : (m_px == 2047) ? 2047 : m_px + 1;
      m_py = !vs ? 0 : (m_pde && !en && m_py != 1023) ? m_py + 1 : m_py;
      m_pde = en; m_pvs = vs;
      e.r = r; e.g = g; e.b = b; e.hs = hs; e.vs = vs; e.en = en;
      e.x = 11'(m_px); e.y = 10'(m_py);
      q.push_back(e);
      send_word(CKP, r, g, b, hs, vs, en, rsv);
   endtask
   task automatic sendx(input logic [7:0] r, input logic en, input int x, input int y, input logic fs);
      px_t e;
      e.r = r; e.g = 8'h00; e.b = 8'h00; e.hs = 1'b0; e.vs = 1'b1; e.en = en;
      e.fs = fs; e.re = 1'b0; e.x = 11'(x); e.y = 10'(y);
      q.push_back(e);
      send_word(CKP, r, 8'h00, 8'h00, 1'b0, 1'b1, en, 1'b1);
   endtask
   // detect word + 4 verify words; locked must rise on the edge after the fifth word
   task automatic lock_seq();
      idle(CKP);
      chk("hunt_locked", s_lock[1], 0);
      chk("hunt_px_x", s_px[1], 0);
      chk("hunt_px_y", s_py[1], 0);
      repeat (4) idle(CKP);
      pix(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("lock_pre", s_lock[0], 0);
      chk("lock_rise", s_lock[1], 1);
   endtask
   initial begin
      forever begin
         @(posedge clk_in);
         #1;
         cyc++;
         if (pixel_valid) begin
            if (cyc - last_pv < 7) begin
               n_cmp++; n_err++;
               $display("FAIL pv_spacing: got gap %0d expected >= 7", cyc - last_pv);
            end
            last_pv = cyc;
            got.r = red; got.g = green; got.b = blue; got.hs = hsync; got.vs = vsync; got.en = de;
            got.fs = frame_start; got.re = rsvd_err; got.x = px_x; got.y = px_y;
            n_cmp++;
            if (q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_pixel: got %h expected no pixel", got);
            end else begin
               exp_px = q.pop_front();
               if (got !== exp_px) begin
                  n_err++;
                  $display("FAIL pixel: got %h expected %h", got, exp_px);
               end
            end
         end
      end
   end
   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end
   initial begin
      model_clear();
      repeat (3) @(negedge clk_in);
      chk("rst_red", red, 0);
      chk("rst_green", green, 0);
      chk("rst_blue", blue, 0);
      chk("rst_ctrl", {hsync, vsync, de}, 0);
      chk("rst_strobes", {pixel_valid, frame_start, rsvd_err}, 0);
      chk("rst_locked", locked, 0);
      chk("rst_px_x", px_x, 0);
      chk("rst_px_y", px_y, 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk_in);
      lock_seq();
      pix(8'hA5, 8'h3C, 8'hC3, 1'b1, 1'b1, 1'b1, 1'b1);
      pix(8'hA5, 8'h3C, 8'hC3, 1'b1, 1'b1, 1'b1, 1'b0);
      pix(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      pix(8'h12, 8'h34, 8'h56, 1'b0, 1'b0, 1'b1, 1'b1);
      pix(8'h81, 8'h42, 8'h24, 1'b1, 1'b1, 1'b1, 1'b1);
      pix(8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
      pix(8'h7E, 8'hE7, 8'h18, 1'b0, 1'b1, 1'b1, 1'b1);
      idle(BAD);
      pix(8'hFF, 8'h00, 8'h80, 1'b0, 1'b1, 1'b1, 1'b1);
      chk("glitch_locked", s_lock[1], 1);
      idle(BAD);
      idle(BAD);
      model_clear();
      lock_seq();
      sendx(8'h00, 1'b0, 2, 0, 1'b1);
      for (int l = 0; l < 3; l++) begin
         for (int i = 0; i < 1280; i++) sendx(8'(i), 1'b1, i, l, 1'b0);
         for (int j = 0; j < 160; j++) sendx(8'h00, 1'b0, 1280 + j, l + 1, 1'b0);
      end
      idle(BAD);
      idle(BAD);
      model_clear();
      for (int i = 0; i < 7; i++) begin
         idle((i == 2 || i == 6) ? BAD : CKP);
         chk("verify_abort_locked", s_lock[1], 0);
      end
      lock_seq();
      pix(8'hA5, 8'h3C, 8'hC3, 1'b1, 1'b1, 1'b1, 1'b1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk_in);
         ck_bit = CKP[k]; rx0_bit = 1'b1; rx1_bit = 1'b1; rx2_bit = 1'b1; rx3_bit = 1'b1;
      end
      @(negedge clk_in);
      rst_n = 1'b0;
      #1;
      chk("arst_locked", locked, 0);
      chk("arst_colour", {red, green, blue}, 0);
      chk("arst_ctrl", {hsync, vsync, de, pixel_valid, frame_start, rsvd_err}, 0);
      chk("arst_px", {px_x, px_y}, 0);
      ck_bit = 1'b0; rx0_bit = 1'b0; rx1_bit = 1'b0; rx2_bit = 1'b0; rx3_bit = 1'b0;
      model_clear();
      repeat (2) @(negedge clk_in);
      rst_n = 1'b1;
      repeat (3) @(negedge clk_in);
      lock_seq();
      pix(8'h5A, 8'hC3, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b1);
      pix(8'h01, 8'h02, 8'h03, 1'b1, 1'b1, 1'b0, 1'b1);
      repeat (20) @(negedge clk_in);
      chk("queue_drained", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
